// File: rtl/bus_slave_responder_if.sv
// ---------------------------------------------------------------------------
// bus_slave_responder_if
//   Serial bus bundle between the two-master bus controller and one slave.
//   master modport: drives select, direction, serial address/data strobes;
//                   receives read data, ready, response and split.
//   slave modport : the mirror image, used by bus_slave_responder.
//   Signals:
//     sel, read_write, a_in, a_valid, d_in, d_valid   controller -> slave
//     d_out, d_out_valid, ready, response[1:0], split slave -> controller
// ---------------------------------------------------------------------------
interface bus_slave_responder_if;
  logic       sel;
  logic       read_write;
  logic       a_in;
  logic       a_valid;
  logic       d_in;
  logic       d_valid;
  logic       d_out;
  logic       d_out_valid;
  logic       ready;
  logic [1:0] response;
  logic       split;

  modport master (
    output sel, read_write, a_in, a_valid, d_in, d_valid,
    input  d_out, d_out_valid, ready, response, split
  );

  modport slave (
    input  sel, read_write, a_in, a_valid, d_in, d_valid,
    output d_out, d_out_valid, ready, response, split
  );
endinterface

// File: rtl/bus_slave_responder.sv
// ---------------------------------------------------------------------------
// bus_slave_responder
//   Serial-bus slave behind one select line. Shifts in an LSB-first address,
//   then either shifts in a write word or returns a word from the internal
//   register file serially, and reports OKAY/ERROR for one cycle at the end.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - bus_slave_responder_if.slave (select, serial address/data in,
//            serial data out, ready, response, split)
//   Parameters: ADDR_W (>=2), DATA_W (>=2), DEPTH, READ_LAT (>=1).
//   Optional feature macro: BUS_SLAVE_SPLIT_EN -- when defined, split is
//   high in every read wait cycle; otherwise split is tied low.
// ---------------------------------------------------------------------------
module bus_slave_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bus_slave_responder_if.slave   bus
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_CNT = (ADDR_W > DATA_W) ?
                           ((ADDR_W > READ_LAT) ? ADDR_W : READ_LAT) :
                           ((DATA_W > READ_LAT) ? DATA_W : READ_LAT);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]  ADDR_BITS = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DATA_BITS = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WAIT, S_RDATA, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rw_q, rw_d;
  logic                legal_q, legal_d;
  logic                ready_q, ready_d;
  logic [1:0]          response_q, response_d;
  logic                d_out_q, d_out_d;
  logic                d_out_valid_q, d_out_valid_d;
  logic                addr_cap;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rw_d          = rw_q;
    legal_d       = legal_q;
    response_d    = RESP_OKAY;
    d_out_d       = 1'b0;
    d_out_valid_d = 1'b0;
    addr_cap      = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sel && bus.a_valid) begin
          state_d  = S_ADDR;
          rw_d     = bus.read_write;
          addr_d   = {bus.a_in, addr_q[ADDR_W-1:1]};
          cnt_d    = CNT_ONE;
          addr_cap = 1'b1;
        end
      end
      S_ADDR: begin
        if (!bus.sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.a_valid) begin
          addr_d   = {bus.a_in, addr_q[ADDR_W-1:1]};
          cnt_d    = cnt_q + 1'b1;
          addr_cap = 1'b1;
        end
      end
      S_WDATA: begin
        if (!bus.sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.d_valid) begin
          data_d = {bus.d_in, data_q[DATA_W-1:1]};
          if (cnt_q == DATA_LAST) begin
            // An out-of-range write still consumes the full word, then drops it.
            mem_we     = legal_q;
            response_d = legal_q ? RESP_OKAY : RESP_ERROR;
            state_d    = S_RESP;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!bus.sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          // rd_data_q has held the addressed word since the last address edge.
          state_d       = S_RDATA;
          d_out_d       = rd_data_q[0];
          d_out_valid_d = 1'b1;
          data_d        = {1'b0, rd_data_q[DATA_W-1:1]};
          cnt_d         = CNT_ONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RDATA: begin
        if (!bus.sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DATA_BITS) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          d_out_d       = data_q[0];
          d_out_valid_d = 1'b1;
          data_d        = {1'b0, data_q[DATA_W-1:1]};
          cnt_d         = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Address completion is shared by IDLE and ADDR so the decision uses the
    // freshly shifted word, compared over its full width.
    if (addr_cap && (cnt_d == ADDR_BITS)) begin
      cnt_d   = '0;
      legal_d = ({1'b0, addr_d} < DEPTH_EXT);
      if (rw_d) begin
        state_d = S_WDATA;
      end else if (legal_d) begin
        state_d = S_WAIT;
      end else begin
        state_d    = S_RESP;
        response_d = RESP_ERROR;
      end
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      rw_q          <= 1'b0;
      legal_q       <= 1'b0;
      ready_q       <= 1'b1;
      response_q    <= RESP_OKAY;
      d_out_q       <= 1'b0;
      d_out_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      rw_q          <= rw_d;
      legal_q       <= legal_d;
      ready_q       <= ready_d;
      response_q    <= response_d;
      d_out_q       <= d_out_d;
      d_out_valid_q <= d_out_valid_d;
    end
  end

  // Register file: no reset. The read port follows the next address so the
  // word is already registered when the first wait cycle begins; a read of
  // an illegal index is harmless because that path never reaches RDATA.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q[IDX_W-1:0]] <= data_d;
    end
    rd_data_q <= mem[addr_d[IDX_W-1:0]];
  end

`ifdef BUS_SLAVE_SPLIT_EN
  logic split_q, split_d;
  assign split_d = (state_d == S_WAIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      split_q <= 1'b0;
    end else begin
      split_q <= split_d;
    end
  end
  assign bus.split = split_q;
`else
  assign bus.split = 1'b0;
`endif

  assign bus.ready       = ready_q;
  assign bus.response    = response_q;
  assign bus.d_out       = d_out_q;
  assign bus.d_out_valid = d_out_valid_q;

endmodule
